hdmi_video_sequencer: RTL and testbench
=======================================

# hdmi_video_sequencer

Sequences the three TMDS 8b/10b channel encoders for HDMI/DVI video output. A free-running raster counter produces, per pixel clock, each encoder's data-enable and control-vector inputs: video data period, HSYNC/VSYNC on channel 0, video preamble (CTL0..CTL3), and leading video guard band codes for a downstream raw-symbol mux. It sits between the pixel source and the three encoder instances, and also gives the pixel source its coordinates.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, 1 = active-high hsync, 0 = active-low
- VSYNC_POL, 0, as HSYNC_POL, for vsync
- DVI_MODE, 0, 1 = suppress preamble and guard band (plain DVI)

Ports:
- clk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low holds raster at (0,0) and drives idle outputs
- den  out  1  data enable, common to all three encoders
- c0  out  2  channel 0 control: {vsync, hsync} at output polarity
- c1  out  2  channel 1 control: {CTL1, CTL0}
- c2  out  2  channel 2 control: {CTL3, CTL2}
- gb  out  1  guard band: downstream mux replaces encoder symbols with gb_code*
- gb_code0, gb_code2  out  10  constant 10'b1011001100
- gb_code1  out  10  constant 10'b0100110011
- pix_x  out  12  column of the pixel accepted with den
- pix_y  out  12  row of the pixel accepted with den
- frame_start  out  1  one-cycle pulse, position (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is the vertical sum. Internal 12-bit counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1).
- Raster order per line: active, front porch, sync, back porch. The same order applies per frame.
- Counter advance: h increments each cycle while en=1. When h = H_TOTAL-1, h wraps to 0 and v increments. When v = V_TOTAL-1 as well, v wraps to 0.
- Active: h<H_ACTIVE and v<V_ACTIVE. In active, den=1, pix_x=h, pix_y=v, c0/c1/c2 hold their last control values, and gb=0.
- hsync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync is asserted for whole lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. An asserted sync drives its POL level; otherwise it drives ~POL.
- A "next line active" condition holds when v<V_ACTIVE-1 or v=V_TOTAL-1.
- Preamble: next line active, DVI_MODE=0, and h in [H_TOTAL-10, H_TOTAL-3] (8 clocks). Drives {CTL3..CTL0} = 4'b0001, so c1=2'b01 and c2=2'b00.
- Guard band: same condition, with h in [H_TOTAL-2, H_TOTAL-1]. Drives gb=1, c1=c2=2'b00, den=0.
- All other non-active clocks: den=0, gb=0, c1=c2=2'b00, and c0 carries the sync levels.
- While en=0: counters are held at 0, outputs are forced to their reset values, and no frame_start is issued. When en rises, the raster starts at (0,0).
- Preamble and guard band constraint: H_FP+H_SYNC+H_BP ≥ 10 is required. Preamble and guard band must lie in blanking; this is a compile-time assertion.

## Timing
- All outputs are registered. Outputs in cycle t+1 reflect counter position (h,v) of cycle t. Latency from counter to output is 1 clock.
- The encoder registers its symbol one more clock later. The pixel source must present d for (pix_x,pix_y) combinationally in the same cycle den=1.
- frame_start is asserted in the same cycle as the den for (0,0). It spans exactly one clock per frame.
- Guard band ends on the clock immediately before the first den of the line. There is no gap.
- Reset (asynchronous, any time, including mid-line):
  - h=v=0, den=0, gb=0, frame_start=0, pix_x=pix_y=0
  - c0={~VSYNC_POL, ~HSYNC_POL}, c1=c2=2'b00
  - gb_code* are constants, unaffected by reset.
- After rst falls with en=1, the first output cycle corresponds to (0,0).

## Test plan
- Defaults, full frame: den high for exactly 640×480 = 307200 clocks per 800×525 = 420000 clocks, and frame_start pulses once every 420000 clocks.
- Line 0 boundaries:
  - den rises at output position h=0 and falls after h=639.
  - c0[0]=0 for exactly 96 clocks, starting at h=656.
- Line 479 → 480: no preamble or guard band at the end of line 479. The end of line 524 has c1=01 for 8 clocks, then gb=1 for 2 clocks, then den=1.
- DVI_MODE=1: gb is never 1 and c1=c2=00 always. Other outputs are identical to the default run.
- en low mid-line at h=300, v=10 for 5 clocks, then high: outputs idle (den=0, c0=2'b11) during the hold, then frame_start is asserted with pix_x=pix_y=0.
- rst pulsed asynchronously between clock edges during a preamble: outputs go to reset values immediately, and the raster restarts at (0,0) after release.

Source files
------------

// File: rtl/hdmi_video_sequencer.sv
// hdmi_video_sequencer
//   Free-running raster generator that drives the data-enable and control
//   vectors of three TMDS 8b/10b channel encoders. It also reports the
//   coordinates of the pixel being accepted back to the pixel source.
//   Each line (and each frame) runs in this order: active, front porch,
//   sync, back porch.
//
//   Ports
//     clk          pixel clock; every flop updates on its rising edge
//     rst          asynchronous, active-high reset
//     en           run enable; low holds the raster at (0,0) with idle outputs
//     den          data enable, shared by all three encoders
//     c0           channel 0 control {vsync, hsync} at output polarity
//     c1           channel 1 control {CTL1, CTL0}
//     c2           channel 2 control {CTL3, CTL2}
//     gb           guard band; downstream mux substitutes gb_code* symbols
//     gb_code0..2  constant video guard band symbols
//     pix_x/pix_y  coordinates of the pixel accepted with den
//     frame_start  one-cycle pulse together with the den of pixel (0,0)
//
//   All outputs are registered. An output in cycle t+1 describes the raster
//   position held by the counters in cycle t.

module hdmi_video_sequencer #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int DVI_MODE  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        den,
  output logic [1:0]  c0,
  output logic [1:0]  c1,
  output logic [1:0]  c2,
  output logic        gb,
  output logic [9:0]  gb_code0,
  output logic [9:0]  gb_code1,
  output logic [9:0]  gb_code2,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT_L    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] PRE_START  = 12'(H_TOTAL - 10);
  localparam logic [11:0] GB_START   = 12'(H_TOTAL - 2);
  localparam logic [11:0] V_ACT_L    = 12'(V_ACTIVE);
  localparam logic [11:0] V_ACT_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

  localparam logic       HPOL      = (HSYNC_POL != 0);
  localparam logic       VPOL      = (VSYNC_POL != 0);
  localparam logic       HDMI_ON   = (DVI_MODE == 0);
  localparam logic [1:0] C0_IDLE   = {~VPOL, ~HPOL};

  // Preamble (8 clocks) and guard band (2 clocks) must fit inside blanking.
  if (H_FP + H_SYNC + H_BP < 10) begin : g_blank_too_short
    $error("hdmi_video_sequencer: horizontal blanking shorter than preamble + guard band");
  end

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_PREAMBLE,
    REG_GUARD,
    REG_BLANK
  } region_e;

  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;
  logic        den_q, den_d;
  logic [1:0]  c0_q, c0_d;
  logic [1:0]  c1_q, c1_d;
  logic [1:0]  c2_q, c2_d;
  logic        gb_q, gb_d;
  logic [11:0] pix_x_q, pix_x_d;
  logic [11:0] pix_y_q, pix_y_d;
  logic        frame_start_q, frame_start_d;

  logic        h_last;
  logic        hsync_on;
  logic        vsync_on;
  logic        next_line_active;
  region_e     region;

  // Raster position classification
  always_comb begin
    hsync_on         = (h_q >= HS_START) && (h_q < HS_END);
    vsync_on         = (v_q >= VS_START) && (v_q < VS_END);
    // The line after this one carries video: either still inside the active
    // rows, or the last row of the frame wrapping back to row 0.
    next_line_active = (v_q < V_ACT_LAST) || (v_q == V_LAST);

    region = REG_BLANK;
    if ((h_q < H_ACT_L) && (v_q < V_ACT_L)) begin
      region = REG_ACTIVE;
    end else if (HDMI_ON && next_line_active && (h_q >= GB_START)) begin
      region = REG_GUARD;
    end else if (HDMI_ON && next_line_active && (h_q >= PRE_START)) begin
      region = REG_PREAMBLE;
    end
  end

  // Counter advance
  always_comb begin
    h_last = (h_q == H_LAST);
    h_d    = h_last ? '0 : h_q + 12'd1;
    v_d    = v_q;
    if (h_last) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 12'd1;
    end
    if (!en) begin
      h_d = '0;
      v_d = '0;
    end
  end

  // Next-state of the registered outputs
  always_comb begin
    den_d         = 1'b0;
    gb_d          = 1'b0;
    c0_d          = {vsync_on ? VPOL : ~VPOL, hsync_on ? HPOL : ~HPOL};
    c1_d          = 2'b00;
    c2_d          = 2'b00;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = (h_q == '0) && (v_q == '0);

    unique case (region)
      REG_ACTIVE: begin
        den_d   = 1'b1;
        pix_x_d = h_q;
        pix_y_d = v_q;
        // Control inputs are ignored by the encoder during data; hold them.
        c0_d    = c0_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
      end
      REG_PREAMBLE: c1_d = 2'b01;  // {CTL3..CTL0} = 4'b0001
      REG_GUARD:    gb_d = 1'b1;
      REG_BLANK:    ;
      default:      ;
    endcase

    if (!en) begin
      den_d         = 1'b0;
      gb_d          = 1'b0;
      c0_d          = C0_IDLE;
      c1_d          = 2'b00;
      c2_d          = 2'b00;
      pix_x_d       = '0;
      pix_y_d       = '0;
      frame_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      den_q         <= 1'b0;
      gb_q          <= 1'b0;
      c0_q          <= C0_IDLE;
      c1_q          <= 2'b00;
      c2_q          <= 2'b00;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      den_q         <= den_d;
      gb_q          <= gb_d;
      c0_q          <= c0_d;
      c1_q          <= c1_d;
      c2_q          <= c2_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign den         = den_q;
  assign gb          = gb_q;
  assign c0          = c0_q;
  assign c1          = c1_q;
  assign c2          = c2_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;

  assign gb_code0 = 10'b1011001100;
  assign gb_code1 = 10'b0100110011;
  assign gb_code2 = 10'b1011001100;

endmodule

// File: tb/tb_hdmi_video_sequencer.sv
// Bench for hdmi_video_sequencer on a reduced raster (31x13). Instance a
// uses HDMI mode with active-low syncs; instance b uses DVI mode with
// active-high syncs. Expected outputs come from a raster model computed
// from a linear pixel index with division/modulo.

module tb_hdmi_video_sequencer;

  localparam int HA = 16, HF = 4, HS = 6, HB = 5;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic        den_a, gb_a, fs_a, den_b, gb_b, fs_b;
  logic [1:0]  c0_a, c1_a, c2_a, c0_b, c1_b, c2_b;
  logic [9:0]  g0_a, g1_a, g2_a, g0_b, g1_b, g2_b;
  logic [11:0] px_a, py_a, px_b, py_b;

  hdmi_video_sequencer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(0), .DVI_MODE(0)
  ) u_a (
    .clk(clk), .rst(rst), .en(en), .den(den_a), .c0(c0_a), .c1(c1_a), .c2(c2_a),
    .gb(gb_a), .gb_code0(g0_a), .gb_code1(g1_a), .gb_code2(g2_a),
    .pix_x(px_a), .pix_y(py_a), .frame_start(fs_a)
  );

  hdmi_video_sequencer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1), .VSYNC_POL(1), .DVI_MODE(1)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .den(den_b), .c0(c0_b), .c1(c1_b), .c2(c2_b),
    .gb(gb_b), .gb_code0(g0_b), .gb_code1(g1_b), .gb_code2(g2_b),
    .pix_x(px_b), .pix_y(py_b), .frame_start(fs_b)
  );

  logic [32:0] obs_a, obs_b, exp_a, exp_b;
  assign obs_a = {den_a, gb_a, c0_a, c1_a, c2_a, fs_a, px_a, py_a};
  assign obs_b = {den_b, gb_b, c0_b, c1_b, c2_b, fs_b, px_b, py_b};

  int checks = 0;
  int errors = 0;
  int mpos = 0;       // model raster index currently held by the counters
  int last_pos = -1;  // raster index the outputs currently describe

  // {den, gb, c0[1:0], c1[1:0], c2[1:0], frame_start} for a raster index
  function automatic logic [8:0] ctl_for(int pos, bit dvi, bit hp, bit vp);
    int  h, v;
    bit  act, hs_on, vs_on, nla, pre, grd;
    h     = pos % HT;
    v     = pos / HT;
    act   = (h < HA) && (v < VA);
    hs_on = (h >= HA + HF) && (h < HA + HF + HS);
    vs_on = (v >= VA + VF) && (v < VA + VF + VS);
    nla   = (v < VA - 1) || (v == VT - 1);
    pre   = !dvi && nla && (h >= HT - 10) && (h <= HT - 3);
    grd   = !dvi && nla && (h >= HT - 2);
    return {act, grd, (vs_on ? vp : !vp), (hs_on ? hp : !hp),
            (pre ? 2'b01 : 2'b00), 2'b00, (pos == 0)};
  endfunction

  function automatic logic [32:0] idle_vec(bit hp, bit vp);
    return {1'b0, 1'b0, !vp, !hp, 2'b00, 2'b00, 1'b0, 24'd0};
  endfunction

  // Advance one clock and update the model expectation, then settle past the edge.
  task automatic step();
    logic [8:0]  ca, cb;
    logic [23:0] pix;
    @(posedge clk);
    if (rst || !en) begin
      exp_a    = idle_vec(1'b0, 1'b0);
      exp_b    = idle_vec(1'b1, 1'b1);
      mpos     = 0;
      last_pos = -1;
    end else begin
      ca  = ctl_for(mpos, 1'b0, 1'b0, 1'b0);
      cb  = ctl_for(mpos, 1'b1, 1'b1, 1'b1);
      pix = {12'(mpos % HT), 12'(mpos / HT)};
      exp_a    = {ca, ca[8] ? pix : exp_a[23:0]};
      exp_b    = {cb, cb[8] ? pix : exp_b[23:0]};
      last_pos = mpos;
      mpos     = (mpos + 1) % FT;
    end
    #1;
  endtask

  task automatic test_reset();
    exp_a = idle_vec(1'b0, 1'b0);
    exp_b = idle_vec(1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_a !== exp_a) begin
      errors++; $display("FAIL reset_a got %h exp %h", obs_a, exp_a);
    end
    checks++;
    if (obs_b !== exp_b) begin
      errors++; $display("FAIL reset_b got %h exp %h", obs_b, exp_b);
    end
    checks++;
    if ({g0_a, g1_a, g2_a} !== {10'b1011001100, 10'b0100110011, 10'b1011001100}) begin
      errors++; $display("FAIL gb_codes got %b %b %b exp 1011001100 0100110011 1011001100", g0_a, g1_a, g2_a);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_a !== exp_a) begin
        errors++; $display("FAIL reset_hold got %h exp %h", obs_a, exp_a);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    int den_cnt = 0, fs_cnt = 0, fs_first = -1, fs_second = -1;
    int c1_cnt = 0, gb_cnt = 0, dvi_bad = 0;
    int hs_cnt = 0, hs_first = -1;
    int l5_ctl = 0, ll_pre = 0, ll_gb = 0;
    logic prev_gb = 1'b0;
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      checks++;
      if (obs_a !== exp_a) begin
        errors++; $display("FAIL frame_a i=%0d got %h exp %h", i, obs_a, exp_a);
      end
      checks++;
      if (obs_b !== exp_b) begin
        errors++; $display("FAIL frame_b i=%0d got %h exp %h", i, obs_b, exp_b);
      end
      if (prev_gb && !gb_a) begin
        checks++;
        if (den_a !== 1'b1) begin
          errors++; $display("FAIL gb_to_den i=%0d den %b exp 1", i, den_a);
        end
      end
      prev_gb = gb_a;
      den_cnt += int'(den_a);
      c1_cnt  += int'(c1_a == 2'b01);
      gb_cnt  += int'(gb_a);
      if (gb_b || c1_b != 2'b00 || c2_b != 2'b00) dvi_bad++;
      if (fs_a) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i; else fs_second = i;
      end
      if (i < FT && last_pos / HT == 0 && !c0_a[0]) begin
        if (hs_first < 0) hs_first = last_pos % HT;
        hs_cnt++;
      end
      if (last_pos / HT == VA - 1 && (c1_a != 2'b00 || gb_a)) l5_ctl++;
      if (i < FT && last_pos / HT == VT - 1) begin
        ll_pre += int'(c1_a == 2'b01);
        ll_gb  += int'(gb_a);
      end
    end
    checks++;
    if (den_cnt != 2 * HA * VA) begin errors++; $display("FAIL den_count got %0d exp %0d", den_cnt, 2 * HA * VA); end
    checks++;
    if (fs_cnt != 2 || fs_first != 0 || fs_second != FT) begin
      errors++; $display("FAIL frame_start got cnt=%0d at %0d,%0d exp cnt=2 at 0,%0d", fs_cnt, fs_first, fs_second, FT);
    end
    checks++;
    if (hs_cnt != HS || hs_first != HA + HF) begin
      errors++; $display("FAIL hsync_line0 got %0d from h=%0d exp %0d from h=%0d", hs_cnt, hs_first, HS, HA + HF);
    end
    checks++;
    if (c1_cnt != 2 * 8 * VA || gb_cnt != 2 * 2 * VA) begin
      errors++; $display("FAIL preamble_gb_count got %0d/%0d exp %0d/%0d", c1_cnt, gb_cnt, 16 * VA, 4 * VA);
    end
    checks++;
    if (l5_ctl != 0) begin errors++; $display("FAIL last_active_line_ctl got %0d exp 0", l5_ctl); end
    checks++;
    if (ll_pre != 8 || ll_gb != 2) begin
      errors++; $display("FAIL last_line_preamble got pre=%0d gb=%0d exp pre=8 gb=2", ll_pre, ll_gb);
    end
    checks++;
    if (dvi_bad != 0) begin errors++; $display("FAIL dvi_ctl got %0d bad cycles exp 0", dvi_bad); end
  endtask

  task automatic test_en_hold();
    int guard = 0;
    while (mpos != 2 * HT + 10 && guard < 2 * FT) begin
      step();
      guard++;
    end
    checks++;
    if (mpos != 2 * HT + 10) begin errors++; $display("FAIL en_hold_reach got %0d exp %0d", mpos, 2 * HT + 10); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (den_a !== 1'b0 || c0_a !== 2'b11 || fs_a !== 1'b0) begin
        errors++; $display("FAIL en_hold_idle got den=%b c0=%b fs=%b exp den=0 c0=11 fs=0", den_a, c0_a, fs_a);
      end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL en_hold_b got %h exp %h", obs_b, exp_b); end
    end
    en = 1'b1;
    step();
    checks++;
    if (fs_a !== 1'b1 || den_a !== 1'b1 || px_a !== 12'd0 || py_a !== 12'd0) begin
      errors++; $display("FAIL en_restart got fs=%b den=%b x=%0d y=%0d exp fs=1 den=1 x=0 y=0", fs_a, den_a, px_a, py_a);
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (c1_a !== 2'b01 && guard < 2 * FT) begin
      step();
      guard++;
    end
    checks++;
    if (c1_a !== 2'b01) begin errors++; $display("FAIL find_preamble got c1=%b exp 01", c1_a); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_a !== idle_vec(1'b0, 1'b0)) begin
      errors++; $display("FAIL async_reset_a got %h exp %h", obs_a, idle_vec(1'b0, 1'b0));
    end
    checks++;
    if (obs_b !== idle_vec(1'b1, 1'b1)) begin
      errors++; $display("FAIL async_reset_b got %h exp %h", obs_b, idle_vec(1'b1, 1'b1));
    end
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < FT; i++) begin
      step();
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL post_reset_a i=%0d got %h exp %h", i, obs_a, exp_a); end
      if (i == 0) begin
        checks++;
        if (fs_a !== 1'b1 || px_a !== 12'd0 || py_a !== 12'd0) begin
          errors++; $display("FAIL post_reset_origin got fs=%b x=%0d y=%0d exp fs=1 x=0 y=0", fs_a, px_a, py_a);
        end
      end
    end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 3000; i++) begin
      step();
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL rand_a i=%0d got %h exp %h", i, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL rand_b i=%0d got %h exp %h", i, obs_b, exp_b); end
      if ($urandom_range(0, 40) == 0) en = ~en;
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_en_hold();
    test_async_reset();
    test_random_en();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
